dsi_line_scheduler: RTL and testbench

- Sequences the DSI packet engine from SPI-delivered pixel lines.
- Takes command bytes from the SPI receiver: 0x3F starts a frame, 0x6B starts a line.
- Emits sync short packets, then one RGB888 long packet per line, paying out bytes from the line FIFO.
- Pads short or underrun lines to full length. Sits between the SPI receiver/line FIFO and the HS packet engine.

---
 rtl/dsi_sched_pkg.sv | 18 +
 rtl/dsi_cmd_pending.sv | 39 +++
 rtl/dsi_line_scheduler.sv | 144 ++++++++++++++
 tb/tb_dsi_line_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_sched_pkg.sv
// dsi_sched_pkg: FSM state encoding, DSI data types and command bytes for the line scheduler.
package dsi_sched_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_VS,
        ST_SYNC_HS,
        ST_WAIT_DATA,
        ST_PAYLOAD,
        ST_GAP,
        ST_SYNC_VE
    } sched_state_t;
    localparam logic [5:0] DT_VSS = 6'h01;
    localparam logic [5:0] DT_VSE = 6'h11;
    localparam logic [5:0] DT_HSS = 6'h21;
    localparam logic [5:0] DT_RGB888 = 6'h3E;
    localparam logic [7:0] CMD_FRAME_BYTE = 8'h3F;
    localparam logic [7:0] CMD_LINE_BYTE = 8'h6B;
endpackage

// File: rtl/dsi_cmd_pending.sv
// dsi_cmd_pending: one-deep command latch with line_ended flag and sticky overrun detect.
module dsi_cmd_pending import dsi_sched_pkg::*; #(
    parameter logic [7:0] CMD_FRAME = CMD_FRAME_BYTE,
    parameter logic [7:0] CMD_LINE = CMD_LINE_BYTE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_i,
    input  logic       line_end_i,
    input  logic       clr_i,
    output logic       full_o,
    output logic       is_frame_o,
    output logic       line_ended_o,
    output logic       err_overrun_o
);
    logic hit;
    logic take;
    always_comb begin
        hit = cmd_valid_i && (cmd_i == CMD_FRAME || cmd_i == CMD_LINE);
        take = hit && (!full_o || clr_i);
    end
    // a command landing in the clearing cycle is accepted, not dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            full_o <= 1'b0;
            is_frame_o <= 1'b0;
            line_ended_o <= 1'b0;
            err_overrun_o <= 1'b0;
        end else begin
            full_o <= take || (full_o && !clr_i);
            if (take)
                is_frame_o <= cmd_i == CMD_FRAME;
            line_ended_o <= take ? line_end_i : (clr_i ? 1'b0 : (line_ended_o || line_end_i));
            if (hit && full_o && !clr_i)
                err_overrun_o <= 1'b1;
        end
    end
endmodule

// File: rtl/dsi_line_scheduler.sv
// dsi_line_scheduler: sequences DSI sync and RGB888 line packets from SPI commands and the line FIFO.
// Build option DSI_VSYNC_END_EN appends a VSync-end packet after the last line of each frame.
module dsi_line_scheduler import dsi_sched_pkg::*; #(
    parameter int         LINE_BYTES = 480,
    parameter int         LINES_PER_FRAME = 240,
    parameter int         FIFO_AW = 10,
    parameter int         START_THRESHOLD = 64,
    parameter int         LP_GAP_CYCLES = 16,
    parameter logic [7:0] CMD_FRAME = CMD_FRAME_BYTE,
    parameter logic [7:0] CMD_LINE = CMD_LINE_BYTE,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid_i,
    input  logic [7:0]       cmd_i,
    input  logic             line_end_i,
    input  logic [FIFO_AW:0] fifo_level_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_rd_o,
    input  logic             pkt_ready_i,
    output logic             pkt_start_o,
    output logic [5:0]       pkt_dt_o,
    output logic [15:0]      pkt_wc_o,
    input  logic             payload_req_i,
    output logic [7:0]       payload_o,
    output logic [7:0]       line_cnt_o,
    output logic             busy_o,
    output logic             err_short_o,
    output logic             err_overrun_o
);
    localparam int BW = $clog2(LINE_BYTES);
    localparam int GW = $clog2(LP_GAP_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(LINE_BYTES - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(LP_GAP_CYCLES - 1);
    localparam logic [FIFO_AW:0] THRESH = (FIFO_AW + 1)'(START_THRESHOLD);
    localparam logic [7:0] LAST_LINE = 8'(LINES_PER_FRAME - 1);
    localparam logic [15:0] WC_LINE = 16'(LINE_BYTES);
    sched_state_t  state;
    logic [BW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic          pend_full;
    logic          pend_frame;
    logic          line_ended;
    logic          gap_done;
    logic          can_launch;
    logic          byte_take;
    dsi_cmd_pending #(.CMD_FRAME(CMD_FRAME), .CMD_LINE(CMD_LINE)) u_pending (
        .clock(clock),
        .reset(reset),
        .cmd_valid_i(cmd_valid_i),
        .cmd_i(cmd_i),
        .line_end_i(line_end_i),
        .clr_i(gap_done),
        .full_o(pend_full),
        .is_frame_o(pend_frame),
        .line_ended_o(line_ended),
        .err_overrun_o(err_overrun_o)
    );
    // no launch while the previous pulse is still visible to the engine
    always_comb begin
        can_launch = pkt_ready_i && !pkt_start_o;
        byte_take = state == ST_PAYLOAD && payload_req_i;
        fifo_rd_o = byte_take && fifo_level_i != '0;
        payload_o = fifo_rd_o ? fifo_data_i : (byte_take ? PAD_BYTE : 8'h00);
        gap_done = state == ST_GAP && gap_cnt == LAST_GAP;
        busy_o = state != ST_IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            pkt_start_o <= 1'b0;
            pkt_dt_o <= '0;
            pkt_wc_o <= '0;
            line_cnt_o <= '0;
            err_short_o <= 1'b0;
            byte_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            pkt_start_o <= 1'b0;
            case (state)
                ST_IDLE: if (pend_full) begin
                    if (pend_frame)
                        line_cnt_o <= '0;
                    if (can_launch) begin
                        pkt_start_o <= 1'b1;
                        pkt_dt_o <= pend_frame ? DT_VSS : DT_HSS;
                        pkt_wc_o <= '0;
                        state <= pend_frame ? ST_SYNC_HS : ST_WAIT_DATA;
                    end else
                        state <= pend_frame ? ST_SYNC_VS : ST_SYNC_HS;
                end
                ST_SYNC_VS: if (can_launch) begin
                    pkt_start_o <= 1'b1;
                    pkt_dt_o <= DT_VSS;
                    pkt_wc_o <= '0;
                    state <= ST_SYNC_HS;
                end
                ST_SYNC_HS: if (can_launch) begin
                    pkt_start_o <= 1'b1;
                    pkt_dt_o <= DT_HSS;
                    pkt_wc_o <= '0;
                    state <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: if ((fifo_level_i >= THRESH || line_ended) && can_launch) begin
                    pkt_start_o <= 1'b1;
                    pkt_dt_o <= DT_RGB888;
                    pkt_wc_o <= WC_LINE;
                    byte_cnt <= '0;
                    state <= ST_PAYLOAD;
                end
                ST_PAYLOAD: if (payload_req_i) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (fifo_level_i == '0)
                        err_short_o <= 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        gap_cnt <= '0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_done) begin
                        line_cnt_o <= line_cnt_o == LAST_LINE ? 8'h00 : line_cnt_o + 8'h01;
`ifdef DSI_VSYNC_END_EN
                        state <= line_cnt_o == LAST_LINE ? ST_SYNC_VE : ST_IDLE;
`else
                        state <= ST_IDLE;
`endif
                    end
                end
`ifdef DSI_VSYNC_END_EN
                ST_SYNC_VE: if (can_launch) begin
                    pkt_start_o <= 1'b1;
                    pkt_dt_o <= DT_VSE;
                    pkt_wc_o <= '0;
                    state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsi_line_scheduler.sv
// tb_dsi_line_scheduler: randomized line traffic against a queue-based FIFO, engine and packet-order model.
module tb_dsi_line_scheduler;
    localparam int LB = 480;
    localparam int LPF = 16;
    localparam int TH = 64;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cmd_valid_i = 1'b0;
    logic [7:0] cmd_i = 8'h00;
    logic line_end_i = 1'b0;
    logic [10:0] fifo_level_i = '0;
    logic [7:0] fifo_data_i = 8'h00;
    logic fifo_rd_o;
    logic pkt_ready_i = 1'b0;
    logic pkt_start_o;
    logic [5:0] pkt_dt_o;
    logic [15:0] pkt_wc_o;
    logic payload_req_i = 1'b0;
    logic [7:0] payload_o;
    logic [7:0] line_cnt_o;
    logic busy_o;
    logic err_short_o;
    logic err_overrun_o;
    logic [7:0] q[$];
    logic [5:0] exp_dt[$];
    logic [5:0] last_dt = 6'h00;
    int n_cmp = 0, n_bad = 0;
    int eng_rem = 0, pad_cnt = 0, pop_cnt = 0, req_cnt = 0, stray = 0;
    int n_launch = 0, n_rgb = 0, n_vse = 0, exp_vse = 0, idx = 0;
    bit ready_en = 1'b0, m_short = 1'b0, m_ovr = 1'b0;
    dsi_line_scheduler #(.LINE_BYTES(LB), .LINES_PER_FRAME(LPF)) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid_i(cmd_valid_i),
        .cmd_i(cmd_i),
        .line_end_i(line_end_i),
        .fifo_level_i(fifo_level_i),
        .fifo_data_i(fifo_data_i),
        .fifo_rd_o(fifo_rd_o),
        .pkt_ready_i(pkt_ready_i),
        .pkt_start_o(pkt_start_o),
        .pkt_dt_o(pkt_dt_o),
        .pkt_wc_o(pkt_wc_o),
        .payload_req_i(payload_req_i),
        .payload_o(payload_o),
        .line_cnt_o(line_cnt_o),
        .busy_o(busy_o),
        .err_short_o(err_short_o),
        .err_overrun_o(err_overrun_o)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // packet engine and FIFO: drive at negedge, observe 1 time unit later before the next posedge
    always @(negedge clock) begin
        payload_req_i = eng_rem > 0 && $urandom_range(3) != 0;
        pkt_ready_i = ready_en && eng_rem == 0;
        fifo_level_i = 11'(q.size());
        fifo_data_i = q.size() > 0 ? q[0] : 8'h00;
        #1;
        if (payload_req_i) begin
            check("fifo_rd", 32'(fifo_rd_o), 32'(q.size() > 0));
            check("payload", 32'(payload_o), q.size() > 0 ? 32'(q[0]) : 32'h0);
            if (q.size() == 0)
                pad_cnt++;
            req_cnt++;
            eng_rem--;
        end else if (fifo_rd_o)
            stray++;
        if (fifo_rd_o && q.size() > 0) begin
            void'(q.pop_front());
            pop_cnt++;
        end
        if (pkt_start_o) begin
            n_launch++;
            check("launch_expected", 32'(exp_dt.size() > 0), 32'h1);
            if (exp_dt.size() > 0) begin
                last_dt = exp_dt.pop_front();
                check("pkt_dt", 32'(pkt_dt_o), 32'(last_dt));
                check("pkt_wc", 32'(pkt_wc_o), last_dt == 6'h3E ? LB : 0);
            end
            if (pkt_dt_o == 6'h3E) begin
                n_rgb++;
                eng_rem = LB;
            end
            if (pkt_dt_o == 6'h11)
                n_vse++;
        end
    end
    task automatic send_cmd(input logic [7:0] c);
        cmd_valid_i = 1'b1;
        cmd_i = c;
        @(posedge clock);
        #2;
        cmd_valid_i = 1'b0;
    endtask
    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        repeat (4) @(posedge clock);
        for (int i = 0; i < 8000 && !ok; i++) begin
            @(posedge clock);
            #2;
            ok = !busy_o && eng_rem == 0;
        end
        if (!ok)
            check("done_timeout", 32'h0, 32'h1);
    endtask
    task automatic run_line(input int n, input bit frame, input bit do_end, input bit lat, input int hold, input bit dup);
        int avail, exp_pad, p0, l0;
        for (int i = 0; i < n; i++)
            q.push_back(lat ? 8'(i) : 8'($urandom));
        avail = q.size();
        exp_pad = avail >= LB ? 0 : LB - avail;
        if (frame) begin
            idx = 0;
            exp_dt.push_back(6'h01);
        end
        exp_dt.push_back(6'h21);
        exp_dt.push_back(6'h3E);
`ifdef DSI_VSYNC_END_EN
        if (idx == LPF - 1) begin
            exp_dt.push_back(6'h11);
            exp_vse++;
        end
`endif
        idx = (idx + 1) % LPF;
        if (exp_pad > 0)
            m_short = 1'b1;
        pad_cnt = 0;
        p0 = pop_cnt;
        if (hold > 0)
            ready_en = 1'b0;
        send_cmd(frame ? 8'h3F : 8'h6B);
        if (lat) begin
            check("lat_early", 32'(pkt_start_o), 32'h0);
            @(posedge clock);
            #2;
            check("lat_pulse", 32'(pkt_start_o), 32'h1);
        end
        if (dup) begin
            send_cmd(8'h6B);
            m_ovr = 1'b1;
        end
        if (do_end) begin
            line_end_i = 1'b1;
            @(posedge clock);
            #2;
            line_end_i = 1'b0;
        end
        if (hold > 0) begin
            l0 = n_launch;
            repeat (hold) @(posedge clock);
            #2;
            check("hold_no_launch", 32'(n_launch - l0), 32'h0);
            check("hold_busy", 32'(busy_o), 32'h1);
            check("hold_dt", 32'(pkt_dt_o), 32'(last_dt));
            ready_en = 1'b1;
        end
        wait_done();
        check("pads", 32'(pad_cnt), 32'(exp_pad));
        check("pops", 32'(pop_cnt - p0), 32'(LB - exp_pad));
        check("line_cnt", 32'(line_cnt_o), 32'(idx));
        check("err_short", 32'(err_short_o), 32'(m_short));
        check("err_overrun", 32'(err_overrun_o), 32'(m_ovr));
    endtask
    task automatic check_quiet(input string tag);
        check({tag, "_start"}, 32'(pkt_start_o), 32'h0);
        check({tag, "_dt"}, 32'(pkt_dt_o), 32'h0);
        check({tag, "_wc"}, 32'(pkt_wc_o), 32'h0);
        check({tag, "_rd"}, 32'(fifo_rd_o), 32'h0);
        check({tag, "_payload"}, 32'(payload_o), 32'h0);
        check({tag, "_line"}, 32'(line_cnt_o), 32'h0);
        check({tag, "_busy"}, 32'(busy_o), 32'h0);
        check({tag, "_short"}, 32'(err_short_o), 32'h0);
        check({tag, "_ovr"}, 32'(err_overrun_o), 32'h0);
    endtask
    initial begin
        int n, r0, l0, p0, rgb0;
        bit ok;
        repeat (3) @(posedge clock);
        #2;
        check_quiet("reset");
        reset = 1'b0;
        ready_en = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        run_line(LB, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        run_line(30, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        rgb0 = n_rgb;
        run_line(LB, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_line(LB, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        repeat (30) @(posedge clock);
        #2;
        check("overrun_rgb_count", 32'(n_rgb - rgb0), 32'h2);
        run_line(LB, 1'b0, 1'b0, 1'b0, 50, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(560);
            run_line(n, 1'b0, (q.size() + n < TH) || $urandom_range(1) == 1, 1'b0,
                     $urandom_range(1) == 1 ? $urandom_range(8) : 0, $urandom_range(3) == 0);
        end
        do
            run_line(LB, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        while (idx != 0);
        for (int i = 0; i < LB; i++)
            q.push_back(8'($urandom));
        exp_dt.push_back(6'h21);
        exp_dt.push_back(6'h3E);
        send_cmd(8'h6B);
        r0 = req_cnt;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clock);
            #2;
            ok = req_cnt - r0 >= 100;
        end
        if (!ok)
            check("reset_wait_timeout", 32'h0, 32'h1);
        reset = 1'b1;
        eng_rem = 0;
        exp_dt.delete();
        @(posedge clock);
        #2;
        check_quiet("midreset");
        reset = 1'b0;
        p0 = pop_cnt;
        l0 = n_launch;
        repeat (30) @(posedge clock);
        #2;
        check("post_reset_pops", 32'(pop_cnt - p0), 32'h0);
        check("post_reset_launch", 32'(n_launch - l0), 32'h0);
        check("post_reset_busy", 32'(busy_o), 32'h0);
        check("exp_left", 32'(exp_dt.size()), 32'h0);
        check("vse_cnt", 32'(n_vse), 32'(exp_vse));
        check("stray_pops", 32'(stray), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
